// File: rtl/clkdiv_bank.sv
// Bank of NCH programmable square-wave clock dividers with per-channel tick pulses.
// Optional macro CLKDIV_BANK_IMMEDIATE_EN: divisor writes take effect on the next edge.
module clkdiv_bank #(
    parameter int unsigned NCH          = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = 49999999
) (
    input  logic                                 clkin,
    input  logic                                 rst,
    input  logic [NCH-1:0]                       clken,
    input  logic                                 wr_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
    input  logic [CNT_W-1:0]                     wr_half,
    output logic                                 wr_ready,
    output logic [NCH-1:0]                       clkout,
    output logic [NCH-1:0]                       tick
);

    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] lim [NCH];
    logic [NCH-1:0]   wr_sel;
    logic [NCH-1:0]   wr_acc;
    logic             sel_busy;

`ifndef CLKDIV_BANK_IMMEDIATE_EN
    logic [CNT_W-1:0] pend [NCH];
    logic [NCH-1:0]   pend_valid;
`endif

    // Decode the write target; out-of-range channels select nothing.
    always_comb begin
        wr_sel   = '0;
        sel_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_ch == CH_W'(i)) begin
                wr_sel[i] = 1'b1;
`ifndef CLKDIV_BANK_IMMEDIATE_EN
                sel_busy  = pend_valid[i];
`endif
            end
        end
    end

    assign wr_ready = (|wr_sel) & ~sel_busy;
    assign wr_acc   = wr_sel & {NCH{wr_en & wr_ready}};

    // Per-channel counter, divided clock, tick and divisor update.
    always_ff @(posedge clkin) begin
        if (rst) begin
            clkout <= '0;
            tick   <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
                lim[i] <= CNT_W'(DEFAULT_HALF);
`ifndef CLKDIV_BANK_IMMEDIATE_EN
                pend[i] <= '0;
`endif
            end
`ifndef CLKDIV_BANK_IMMEDIATE_EN
            pend_valid <= '0;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                tick[i] <= 1'b0;
`ifdef CLKDIV_BANK_IMMEDIATE_EN
                if (wr_acc[i]) begin
                    lim[i]    <= wr_half;
                    cnt[i]    <= '0;
                    clkout[i] <= 1'b0;
                end else if (clken[i]) begin
                    if (cnt[i] >= lim[i]) begin
                        cnt[i]    <= '0;
                        clkout[i] <= ~clkout[i];
                        tick[i]   <= ~clkout[i];
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
`else
                if (clken[i]) begin
                    if (cnt[i] >= lim[i]) begin
                        cnt[i]    <= '0;
                        clkout[i] <= ~clkout[i];
                        tick[i]   <= ~clkout[i];
                        // Swap divisor only at the end of the high phase: no runt pulse.
                        if (clkout[i] && pend_valid[i]) begin
                            lim[i]        <= pend[i];
                            pend_valid[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else if (pend_valid[i]) begin
                    lim[i]        <= pend[i];
                    pend_valid[i] <= 1'b0;
                    cnt[i]        <= '0;
                end
                // Never collides with an apply: writes are refused while pending.
                if (wr_acc[i]) begin
                    pend[i]       <= wr_half;
                    pend_valid[i] <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank (NCH=4, CNT_W=8, DEFAULT_HALF=3) against a
// phase-length reference model; honours CLKDIV_BANK_IMMEDIATE_EN when defined.
module tb_clkdiv_bank;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int DHALF = 3;

    logic             clkin = 1'b0;
    logic             rst   = 1'b1;
    logic [NCH-1:0]   clken = '1;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_ch = '0;
    logic [CNT_W-1:0] wr_half = '0;
    logic             wr_ready;
    logic [NCH-1:0]   clkout;
    logic [NCH-1:0]   tick;

    int vectors = 0;
    int errors  = 0;

    // Reference model: level, enabled cycles left in current phase, limits.
    logic [NCH-1:0] m_clk  = '0;
    logic [NCH-1:0] m_tick = '0;
    logic           m_rdy  = 1'b1;
    logic           rdy_obs;
    int             m_left [NCH];
    int             m_lim  [NCH];
    int             m_pend [NCH];
    bit             m_pv   [NCH];

    clkdiv_bank #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_HALF(DHALF)) dut (
        .clkin(clkin), .rst(rst), .clken(clken), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_half(wr_half), .wr_ready(wr_ready), .clkout(clkout), .tick(tick)
    );

    always #5 clkin = ~clkin;

    task automatic model_edge();
        logic [NCH-1:0] nt;
        bit acc;
        bit was;
        nt = '0;
`ifdef CLKDIV_BANK_IMMEDIATE_EN
        m_rdy = 1'b1;
`else
        m_rdy = !m_pv[wr_ch];
`endif
        if (rst) begin
            m_clk = '0;
            for (int i = 0; i < NCH; i++) begin
                m_lim[i] = DHALF; m_left[i] = DHALF + 1; m_pv[i] = 0; m_pend[i] = 0;
            end
        end else begin
            acc = wr_en && m_rdy;
            for (int i = 0; i < NCH; i++) begin
`ifdef CLKDIV_BANK_IMMEDIATE_EN
                if (acc && int'(wr_ch) == i) begin
                    m_lim[i] = int'(wr_half); m_clk[i] = 1'b0; m_left[i] = m_lim[i] + 1;
                    continue;
                end
`endif
                if (clken[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        was = m_clk[i];
                        m_clk[i] = ~was;
                        nt[i] = ~was;
`ifndef CLKDIV_BANK_IMMEDIATE_EN
                        if (was && m_pv[i]) begin m_lim[i] = m_pend[i]; m_pv[i] = 0; end
`endif
                        m_left[i] = m_lim[i] + 1;
                    end
                end
`ifndef CLKDIV_BANK_IMMEDIATE_EN
                else if (m_pv[i]) begin
                    m_lim[i] = m_pend[i]; m_pv[i] = 0; m_left[i] = m_lim[i] + 1;
                end
                if (acc && int'(wr_ch) == i) begin m_pend[i] = int'(wr_half); m_pv[i] = 1; end
`endif
            end
        end
        m_tick = nt;
    endtask

    // Advance one clkin edge; returns 1 time unit after the posedge.
    task automatic cycle();
        @(negedge clkin);
        rdy_obs = wr_ready;
        @(posedge clkin);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int first = 0;
        int nticks = 0;
        rst = 1'b1;
        repeat (3) begin
            cycle();
            vectors++;
            if ({clkout, tick, rdy_obs} !== {4'h0, 4'h0, 1'b1}) begin
                errors++;
                $display("FAIL reset: clkout=%h tick=%h rdy=%b required 0 0 1", clkout, tick, rdy_obs);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            cycle();
            vectors++;
            if ({clkout, tick, rdy_obs} !== {m_clk, m_tick, m_rdy}) begin
                errors++;
                $display("FAIL startup c%0d: clkout=%h tick=%h rdy=%b required %h %h %b",
                         c, clkout, tick, rdy_obs, m_clk, m_tick, m_rdy);
            end
            if (clkout[0] && first == 0) first = c;
            if (tick[0]) nticks++;
        end
        vectors++;
        if (first !== 4) begin
            errors++;
            $display("FAIL first_rise: got cycle %0d required 4", first);
        end
        vectors++;
        if (nticks !== 2) begin
            errors++;
            $display("FAIL tick_count: got %0d required 2", nticks);
        end
    endtask

    // Wait (bounded) for clkout[ch] high, then issue one write.
    task automatic write_in_high(input int ch, input int half);
        int k = 0;
        while (clkout[ch] !== 1'b1 && k < 20) begin
            cycle();
            vectors++;
            if ({clkout, tick, rdy_obs} !== {m_clk, m_tick, m_rdy}) begin
                errors++;
                $display("FAIL wait_high: clkout=%h tick=%h rdy=%b required %h %h %b",
                         clkout, tick, rdy_obs, m_clk, m_tick, m_rdy);
            end
            k++;
        end
        vectors++;
        if (k >= 20) begin
            errors++;
            $display("FAIL timeout: clkout[%0d]=%b never high, required 1", ch, clkout[ch]);
        end
        wr_en = 1'b1; wr_ch = 2'(ch); wr_half = CNT_W'(half);
    endtask

    task automatic test_write_high();
        write_in_high(1, 1);
        for (int c = 0; c < 24; c++) begin
            cycle();
            wr_en = 1'b0;
            vectors++;
            if ({clkout, tick, rdy_obs} !== {m_clk, m_tick, m_rdy}) begin
                errors++;
                $display("FAIL write_high c%0d: clkout=%h tick=%h rdy=%b required %h %h %b",
                         c, clkout, tick, rdy_obs, m_clk, m_tick, m_rdy);
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_ch = 2'd2; wr_half = 8'd5;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (c == 0) wr_half = 8'd0;
            else wr_en = 1'b0;
            vectors++;
            if ({clkout, tick, rdy_obs} !== {m_clk, m_tick, m_rdy}) begin
                errors++;
                $display("FAIL back_to_back c%0d: clkout=%h tick=%h rdy=%b required %h %h %b",
                         c, clkout, tick, rdy_obs, m_clk, m_tick, m_rdy);
            end
        end
    endtask

    task automatic test_freeze();
        logic held;
        repeat (3) cycle();
        held = clkout[3];
        clken[3] = 1'b0;
        for (int c = 0; c < 22; c++) begin
            cycle();
            if (c == 9) clken[3] = 1'b1;
            vectors++;
            if ({clkout, tick, rdy_obs} !== {m_clk, m_tick, m_rdy}) begin
                errors++;
                $display("FAIL freeze c%0d: clkout=%h tick=%h rdy=%b required %h %h %b",
                         c, clkout, tick, rdy_obs, m_clk, m_tick, m_rdy);
            end
            if (c < 9) begin
                vectors++;
                if ({clkout[3], tick[3]} !== {held, 1'b0}) begin
                    errors++;
                    $display("FAIL frozen c%0d: clkout3=%b tick3=%b required %b 0",
                             c, clkout[3], tick[3], held);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        write_in_high(1, 2);
        cycle();
        wr_en = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vectors++;
        if ({clkout, tick} !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid: clkout=%h tick=%h required 0 0", clkout, tick);
        end
        for (int c = 0; c < 20; c++) begin
            cycle();
            vectors++;
            if ({clkout, tick, rdy_obs} !== {m_clk, m_tick, m_rdy}) begin
                errors++;
                $display("FAIL after_rst c%0d: clkout=%h tick=%h rdy=%b required %h %h %b",
                         c, clkout, tick, rdy_obs, m_clk, m_tick, m_rdy);
            end
        end
    endtask

`ifdef CLKDIV_BANK_IMMEDIATE_EN
    task automatic test_immediate();
        repeat (5) cycle();
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 8'd0;
        cycle();
        wr_en = 1'b0;
        vectors++;
        if (clkout[0] !== 1'b0) begin
            errors++;
            $display("FAIL immediate_load: clkout0=%b required 0", clkout[0]);
        end
        for (int c = 0; c < 6; c++) begin
            cycle();
            vectors++;
            if (clkout[0] !== ((c % 2) == 0)) begin
                errors++;
                $display("FAIL immediate_toggle c%0d: clkout0=%b required %b",
                         c, clkout[0], (c % 2) == 0);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NCH; i++) clken[i] = ($urandom_range(0, 7) != 0);
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_half = 8'($urandom_range(0, 6));
            rst     = ($urandom_range(0, 199) == 0);
            cycle();
            vectors++;
            if ({clkout, tick, rdy_obs} !== {m_clk, m_tick, m_rdy}) begin
                errors++;
                $display("FAIL random c%0d: clkout=%h tick=%h rdy=%b required %h %h %b",
                         c, clkout, tick, rdy_obs, m_clk, m_tick, m_rdy);
            end
        end
        rst = 1'b0; wr_en = 1'b0; clken = '1;
    endtask

    initial begin
        test_reset();
        test_write_high();
        test_back_to_back();
        test_freeze();
        test_rst_mid();
`ifdef CLKDIV_BANK_IMMEDIATE_EN
        test_immediate();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
